// File: rtl/mu2cgra_stream_driver.sv
// mu2cgra_stream_driver: valid/ready vector streamer (CONST/RAMP/REPLAY), optional MU2CGRA_STALL_COUNTER_EN stall counter
module mu2cgra_stream_driver #(
    parameter int NUM_LANES   = 32,
    parameter int DATA_WIDTH  = 17,
    parameter int DEPTH       = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [1:0]                        cfg_mode,
    input  logic [DATA_WIDTH-1:0]             cfg_base,
    input  logic [COUNT_WIDTH-1:0]            cfg_num_vectors,
    input  logic                              start,
    input  logic                              load_en,
    input  logic [$clog2(DEPTH)-1:0]          load_addr,
    input  logic [$clog2(NUM_LANES)-1:0]      load_lane,
    input  logic [DATA_WIDTH-1:0]             load_data,
    output logic                              busy,
    output logic                              done,
    output logic [COUNT_WIDTH-1:0]            sent_count,
    output logic                              mu2cgra_valid,
    input  logic                              cgra2mu_ready,
`ifdef MU2CGRA_STALL_COUNTER_EN
    output logic [COUNT_WIDTH-1:0]            stall_cycles,
`endif
    output logic [NUM_LANES*DATA_WIDTH-1:0]   mu2cgra
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    state_e                          state_q, state_d;
    logic [1:0]                      mode_q, mode_d;
    logic [DATA_WIDTH-1:0]           base_q, base_d;
    logic [COUNT_WIDTH-1:0]          num_q, num_d, idx_q, idx_d, sent_q, sent_d;
    logic [NUM_LANES*DATA_WIDTH-1:0] data_q, data_d, vec;
    logic [DATA_WIDTH-1:0]           mem [DEPTH][NUM_LANES];
    logic                            first;
    logic [1:0]                      gen_mode;
    logic [DATA_WIDTH-1:0]           gen_base;
    logic [COUNT_WIDTH-1:0]          gen_k;
`ifdef MU2CGRA_STALL_COUNTER_EN
    logic [COUNT_WIDTH-1:0]          stall_q, stall_d;
    assign stall_cycles = stall_q;
`endif

    // In IDLE the generator builds vector 0 from the live config; in RUN it builds the next vector
    assign first    = state_q == IDLE;
    assign gen_mode = first ? cfg_mode : mode_q;
    assign gen_base = first ? cfg_base : base_q;
    assign gen_k    = first ? '0 : idx_q + 1'b1;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign vec[g*DATA_WIDTH +: DATA_WIDTH] =
            gen_mode == 2'd1 ? gen_base + DATA_WIDTH'(gen_k) + DATA_WIDTH'(g) :
            gen_mode == 2'd2 ? mem[gen_k[AW-1:0]][g] : gen_base;
    end

    assign busy          = state_q == RUN;
    assign done          = state_q == DONE;
    assign mu2cgra_valid = busy;
    assign sent_count    = sent_q;
    assign mu2cgra       = data_q;

    // Pattern memory is deliberately unreset; writes are blocked while a run is streaming
    always_ff @(posedge clk) begin
        if (load_en && state_q != RUN) mem[load_addr][load_lane] <= load_data;
    end

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        base_d  = base_q;
        num_d   = num_q;
        idx_d   = idx_q;
        sent_d  = sent_q;
        data_d  = data_q;
`ifdef MU2CGRA_STALL_COUNTER_EN
        stall_d = stall_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                sent_d = '0;
                idx_d  = '0;
`ifdef MU2CGRA_STALL_COUNTER_EN
                stall_d = '0;
`endif
                if (cfg_num_vectors != '0) begin
                    mode_d  = cfg_mode;
                    base_d  = cfg_base;
                    num_d   = cfg_num_vectors;
                    data_d  = vec;
                    state_d = RUN;
                end else state_d = DONE;
            end
            RUN: if (cgra2mu_ready) begin
                sent_d = sent_q + 1'b1;
                if (sent_d == num_q) state_d = DONE;
                else begin
                    idx_d  = idx_q + 1'b1;
                    data_d = vec;
                end
            end else begin
`ifdef MU2CGRA_STALL_COUNTER_EN
                if (stall_q != '1) stall_d = stall_q + 1'b1;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            mode_q  <= '0;
            base_q  <= '0;
            num_q   <= '0;
            idx_q   <= '0;
            sent_q  <= '0;
            data_q  <= '0;
`ifdef MU2CGRA_STALL_COUNTER_EN
            stall_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            base_q  <= base_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            sent_q  <= sent_d;
            data_q  <= data_d;
`ifdef MU2CGRA_STALL_COUNTER_EN
            stall_q <= stall_d;
`endif
        end
    end
endmodule

// File: tb/tb_mu2cgra_stream_driver.sv
// tb_mu2cgra_stream_driver: table-driven runs with a scoreboard of expected vectors plus reset/zero-count sequences
module tb_mu2cgra_stream_driver;
    localparam int NL = 32, DW = 17, CW = 16, VW = NL * DW;

    logic          clk = 1'b0, reset_n, start, load_en, cgra2mu_ready;
    logic [1:0]    cfg_mode;
    logic [DW-1:0] cfg_base, load_data;
    logic [CW-1:0] cfg_num_vectors, sent_count;
    logic [3:0]    load_addr;
    logic [4:0]    load_lane;
    logic          busy, done, mu2cgra_valid;
    logic [VW-1:0] mu2cgra;
`ifdef MU2CGRA_STALL_COUNTER_EN
    logic [CW-1:0] stall_cycles;
`endif

    mu2cgra_stream_driver dut (
        .clk(clk), .reset_n(reset_n), .cfg_mode(cfg_mode), .cfg_base(cfg_base),
        .cfg_num_vectors(cfg_num_vectors), .start(start), .load_en(load_en),
        .load_addr(load_addr), .load_lane(load_lane), .load_data(load_data),
        .busy(busy), .done(done), .sent_count(sent_count), .mu2cgra_valid(mu2cgra_valid),
        .cgra2mu_ready(cgra2mu_ready),
`ifdef MU2CGRA_STALL_COUNTER_EN
        .stall_cycles(stall_cycles),
`endif
        .mu2cgra(mu2cgra)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [16:0] base;
        int          num;
        logic [15:0] rpat;
        int          rlen;
        int          cyc;
        int          stall;
        bit          ld;
    } run_t;

    int            checks = 0, errors = 0;
    logic [DW-1:0] mem_m [16][NL];
    logic [VW-1:0] sbq [$];
    run_t          v [5];

    task automatic chk(input string n, input logic [VW-1:0] a, input logic [VW-1:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, a, e);
        end
    endtask

    function automatic logic [VW-1:0] exp_vec(input logic [1:0] m, input logic [16:0] b, input int k);
        logic [VW-1:0] r;
        for (int i = 0; i < NL; i++)
            r[i*DW +: DW] = m == 2'd1 ? 17'(b + k + i) : m == 2'd2 ? mem_m[k % 16][i] : b;
        return r;
    endfunction

    task automatic load(input int e, input int i, input logic [DW-1:0] d);
        load_en = 1'b1; load_addr = 4'(e); load_lane = 5'(i); load_data = d;
        mem_m[e][i] = d;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic do_run(input run_t t);
        logic [VW-1:0] prev;
        bit            held;
        int            c;
        for (int k = 0; k < t.num; k++) sbq.push_back(exp_vec(t.mode, t.base, k));
        cfg_mode = t.mode; cfg_base = t.base; cfg_num_vectors = CW'(t.num); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_valid_busy", {busy, mu2cgra_valid}, 2'b11);
        held = 0; c = 0; prev = '0;
        while (!done && c < 400) begin
            cgra2mu_ready = t.rpat[c % t.rlen];
            load_en = t.ld && c == 1; load_addr = 4'd15; load_lane = 5'd31; load_data = 17'h1ABCD;
            @(negedge clk);
            chk("valid_in_run", mu2cgra_valid, 1'b1);
            if (held) chk("stall_stable", mu2cgra, prev);
            if (cgra2mu_ready) begin
                if (sbq.size() == 0) chk("sb_underflow", 1, 0);
                else chk("vector_data", mu2cgra, sbq.pop_front());
                held = 0;
            end else begin
                held = 1;
                prev = mu2cgra;
            end
            @(posedge clk); #1;
            c++;
        end
        load_en = 1'b0; cgra2mu_ready = 1'b0;
        chk("cycles_to_done", c, t.cyc);
        chk("done_state", {done, busy, mu2cgra_valid}, 3'b100);
        chk("sent_count", sent_count, t.num);
        chk("sb_drained", sbq.size(), 0);
        sbq.delete();
`ifdef MU2CGRA_STALL_COUNTER_EN
        chk("stall_cycles", stall_cycles, t.stall);
`endif
        @(posedge clk); #1;
        chk("done_one_cycle", done, 1'b0);
        chk("sent_hold", sent_count, t.num);
    endtask

    initial begin
        v[0] = '{2'd0, 17'h00001,  4, 16'h0001, 1,  4, 0, 1'b0};
        v[1] = '{2'd1, 17'h1FFFE,  3, 16'h0001, 1,  3, 0, 1'b0};
        v[2] = '{2'd2, 17'h00000, 20, 16'h0001, 1, 20, 0, 1'b1};
        v[3] = '{2'd1, 17'h00005,  3, 16'h0034, 6,  6, 3, 1'b0};
        v[4] = '{2'd3, 17'h0ABCD,  2, 16'h0001, 2,  3, 1, 1'b0};
        reset_n = 1'b0; start = 1'b0; load_en = 1'b0; cgra2mu_ready = 1'b0;
        cfg_mode = '0; cfg_base = '0; cfg_num_vectors = '0;
        load_addr = '0; load_lane = '0; load_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", {busy, done, mu2cgra_valid, sent_count}, 0);
        chk("reset_data", mu2cgra, 0);
        reset_n = 1'b1;
        for (int e = 0; e < 16; e++)
            for (int i = 0; i < NL; i++) load(e, i, 17'(e * 32 + i));
        for (int t = 0; t < 5; t++) do_run(v[t]);
        chk("ramp_wrap_lane2", exp_vec(2'd1, 17'h1FFFE, 0) >> (2 * DW) & VW'(17'h1FFFF), 0);
        cfg_num_vectors = '0; cfg_mode = 2'd0; start = 1'b1;
        @(negedge clk);
        chk("zero_pre", {busy, done, mu2cgra_valid}, 3'b000);
        @(posedge clk); #1;
        start = 1'b0;
        chk("zero_done", {busy, done, mu2cgra_valid}, 3'b010);
        chk("zero_sent", sent_count, 0);
        @(posedge clk); #1;
        chk("zero_idle", {busy, done, mu2cgra_valid}, 3'b000);
        cfg_mode = 2'd1; cfg_base = '0; cfg_num_vectors = 16'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cgra2mu_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("pre_reset_data", mu2cgra, exp_vec(2'd1, 17'h0, k));
            @(posedge clk); #1;
        end
        chk("pre_reset_sent", sent_count, 2);
        reset_n = 1'b0;
        #1;
        chk("midrun_reset_ctrl", {busy, done, mu2cgra_valid, sent_count}, 0);
        chk("midrun_reset_data", mu2cgra, 0);
        @(posedge clk); #1;
        chk("no_done_after_reset", {busy, done, mu2cgra_valid}, 3'b000);
        reset_n = 1'b1; cgra2mu_ready = 1'b0;
        do_run('{2'd1, 17'h00000, 8, 16'h0001, 1, 8, 0, 1'b0});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
